// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA register address and DMA controller states.
package nes_pkg;

  // CPU address whose write launches an OAM DMA transfer
  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'h4014;

  // OAM DMA controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR suspends the CPU and copies
// 256 bytes from WRAM page {page,8'h00..8'hFF} into OAM, one read/write pair
// per two CPU cycles, with an extra alignment cycle on odd parity.
module oam_dma_ctrl
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wr,
  input  logic [7:0]  wram_data_in,
  output logic        cpu_rdy,
  output logic        oam_dma,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_in,
  output logic        oam_we
);

  dma_state_t r_state;
  logic [7:0] r_page;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic       r_parity;

  dma_state_t w_nextState;
  logic [7:0] w_nextPage;
  logic [7:0] w_nextCnt;
  logic [7:0] w_nextData;

  // Parity tracks even/odd CPU cycles regardless of what the FSM is doing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (cpu_ce) begin
      r_parity <= ~r_parity;
    end
  end

  // FSM state, page, byte counter and read-to-write data holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_page  <= 8'h00;
      r_cnt   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_nextState;
      r_page  <= w_nextPage;
      r_cnt   <= w_nextCnt;
      r_data  <= w_nextData;
    end
  end

  // Next-state logic; nothing moves unless the CPU cycle enable is high
  always_comb begin
    w_nextState = r_state;
    w_nextPage  = r_page;
    w_nextCnt   = r_cnt;
    w_nextData  = r_data;
    if (cpu_ce) begin
      case (r_state)
        IDLE: begin
          if (cpu_wr && (cpu_addr == DMA_REG_ADDR)) begin
            w_nextPage  = cpu_data_out;
            w_nextCnt   = 8'h00;
            w_nextState = HALT;
          end
        end
        HALT: begin
          w_nextState = r_parity ? ALIGN : READ;
        end
        ALIGN: begin
          w_nextState = READ;
        end
        READ: begin
          w_nextData  = wram_data_in;
          w_nextState = WRITE;
        end
        WRITE: begin
          w_nextCnt   = r_cnt + 8'd1;
          w_nextState = (r_cnt == 8'hFF) ? IDLE : READ;
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  // Moore outputs from the registered state; only the OAM strobe sees cpu_ce
  always_comb begin
    cpu_rdy     = (r_state == IDLE);
    oam_dma     = (r_state != IDLE);
    bus_sel     = (r_state == READ);
    dma_addr    = {r_page, r_cnt};
    oam_addr    = r_cnt;
    oam_data_in = r_data;
    oam_we      = (r_state == WRITE) && cpu_ce;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: stimulus pushes expected WRAM reads
// and OAM writes into queues, a negedge monitor pops and compares them.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_wr;
  logic [7:0]  wram_data_in;
  logic        cpu_rdy;
  logic        oam_dma;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;
  logic        oam_we;

  int vectorCount = 0;
  int missCount   = 0;
  int lowCount    = 0;
  int writeCount  = 0;
  int ceMode      = 0;
  logic parityModel;

  logic [15:0] expReadQ[$];
  logic [15:0] expWriteQ[$];

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_ce       (cpu_ce),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_wr       (cpu_wr),
    .wram_data_in (wram_data_in),
    .cpu_rdy      (cpu_rdy),
    .oam_dma      (oam_dma),
    .bus_sel      (bus_sel),
    .dma_addr     (dma_addr),
    .oam_addr     (oam_addr),
    .oam_data_in  (oam_data_in),
    .oam_we       (oam_we)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // WRAM contents: page 2 holds i^5A, page 3 holds i^C3
  function automatic logic [7:0] wramFn(input logic [15:0] a);
    case (a[15:8])
      8'h02:   return a[7:0] ^ 8'h5A;
      8'h03:   return a[7:0] ^ 8'hC3;
      default: return a[7:0];
    endcase
  endfunction

  assign wram_data_in = wramFn(dma_addr);

  // Expected parity: flips on every enabled CPU cycle, cleared by reset
  always @(posedge clk or posedge reset) begin
    if (reset) parityModel <= 1'b0;
    else if (cpu_ce) parityModel <= ~parityModel;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Monitor: count suspended cycles, check every WRAM read and OAM write
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cpu_ce && !cpu_rdy) lowCount++;
      if (bus_sel && cpu_ce) begin
        if (expReadQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL unexpected_read: actual %0h required none", dma_addr);
        end else begin
          checkOutput("dma_addr", {16'h0, dma_addr}, {16'h0, expReadQ.pop_front()});
        end
      end
      if (oam_we) begin
        writeCount++;
        if (expWriteQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL unexpected_write: actual %0h required none", oam_addr);
        end else begin
          logic [15:0] e;
          e = expWriteQ.pop_front();
          checkOutput("oam_addr", {24'h0, oam_addr}, {24'h0, e[15:8]});
          checkOutput("oam_data", {24'h0, oam_data_in}, {24'h0, e[7:0]});
        end
      end
    end
  end

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (ceMode == 1) cpu_ce = 1'($urandom_range(0, 1));
    else cpu_ce = 1'b1;
  endtask

  // Trigger a DMA from the given page; push the 256 expected reads/writes
  task automatic applyStimulus(input logic [7:0] page, input logic [7:0] key,
                               output int lowBase);
    for (int i = 0; i < 256; i++) begin
      expReadQ.push_back({page, 8'(i)});
      expWriteQ.push_back({8'(i), 8'(i) ^ key});
    end
    cpu_addr     = 16'h4014;
    cpu_data_out = page;
    cpu_wr       = 1'b1;
    cpu_ce       = 1'b1;
    lowBase      = lowCount;
    tick();
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic setParity(input logic want);
    ceMode = 0;
    cpu_ce = 1'b1;
    for (int i = 0; i < 4 && parityModel != want; i++) tick();
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tick();
      if (cpu_rdy) done = 1;
    end
    checkOutput({name, "_done"}, {31'h0, done}, 32'h1);
    checkOutput({name, "_readq_left"}, expReadQ.size(), 32'h0);
    checkOutput({name, "_writeq_left"}, expWriteQ.size(), 32'h0);
  endtask

  task automatic waitWrites(input int base, input int n);
    for (int i = 0; i < 2000 && (writeCount - base) < n; i++) tick();
    checkOutput("byte_reached", writeCount - base, n);
  endtask

  initial begin
    int lowBase;
    int wrBase;
    reset = 1'b1; cpu_ce = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 16'h0000; cpu_data_out = 8'h00;

    // Reset-state outputs
    #12;
    checkOutput("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
    checkOutput("rst_oam_dma", {31'h0, oam_dma}, 32'h0);
    checkOutput("rst_bus_sel", {31'h0, bus_sel}, 32'h0);
    checkOutput("rst_oam_we", {31'h0, oam_we}, 32'h0);
    checkOutput("rst_dma_addr", {16'h0, dma_addr}, 32'h0);
    checkOutput("rst_oam_addr", {24'h0, oam_addr}, 32'h0);
    checkOutput("rst_oam_data", {24'h0, oam_data_in}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_ce = 1'b1;
    tick();

    // Even parity in HALT: 513 suspended cycles
    setParity(1'b1);
    applyStimulus(8'h02, 8'h5A, lowBase);
    waitIdle("even");
    checkOutput("even_low_cycles", lowCount - lowBase, 513);

    // Odd parity in HALT: one ALIGN cycle, 514 suspended cycles
    setParity(1'b0);
    applyStimulus(8'h02, 8'h5A, lowBase);
    waitIdle("odd");
    checkOutput("odd_low_cycles", lowCount - lowBase, 514);

    // Random cpu_ce gaps must not drop or duplicate any write
    ceMode = 1;
    applyStimulus(8'h02, 8'h5A, lowBase);
    waitIdle("gappy");
    checkOutput("gappy_last_addr", {24'h0, oam_addr}, 32'h0);
    ceMode = 0;

    // Retrigger at byte 100 with page 7 must be ignored
    wrBase = writeCount;
    applyStimulus(8'h02, 8'h5A, lowBase);
    waitWrites(wrBase, 100);
    cpu_addr = 16'h4014; cpu_data_out = 8'h07; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    waitIdle("retrig");

    // Reset at byte 37 aborts at once; fresh transfer from page 3
    wrBase = writeCount;
    applyStimulus(8'h02, 8'h5A, lowBase);
    waitWrites(wrBase, 37);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
    checkOutput("abort_oam_we", {31'h0, oam_we}, 32'h0);
    checkOutput("abort_oam_dma", {31'h0, oam_dma}, 32'h0);
    expReadQ.delete();
    expWriteQ.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();
    applyStimulus(8'h03, 8'hC3, lowBase);
    waitIdle("restart");

    // Other address writes and reads of the DMA register do nothing
    cpu_addr = 16'h4015; cpu_data_out = 8'h02; cpu_wr = 1'b1;
    tick();
    cpu_addr = 16'h4014; cpu_wr = 1'b0;
    tick();
    cpu_addr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("noop_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
      checkOutput("noop_oam_dma", {31'h0, oam_dma}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU address whose write triggers DMA.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port cpu_ce, input, 1, CPU cycle enable; the FSM advances only on clk edges where cpu_ce=1.
REQ-005 SHALL have port cpu_addr, input, 16, the CPU address bus.
REQ-006 SHALL have port cpu_data_out, input, 8, the CPU write data.
REQ-007 SHALL have port cpu_wr, input, 1, CPU write strobe, 1 = write.
REQ-008 SHALL have port wram_data_in, input, 8, the WRAM read data.
REQ-009 SHALL have port cpu_rdy, output, 1, CPU ready; 0 suspends the CPU.
REQ-010 SHALL have port oam_dma, output, 1, high while DMA owns the bus.
REQ-011 SHALL have port bus_sel, output, 1, WRAM address mux select; 1 = dma_addr.
REQ-012 SHALL have port dma_addr, output, 16, the DMA source address.
REQ-013 SHALL have port oam_addr, output, 8, the OAM write address.
REQ-014 SHALL have port oam_data_in, output, 8, the OAM write data.
REQ-015 SHALL have port oam_we, output, 1, the OAM write strobe.

Function
REQ-016 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE; state, page, cnt, data and parity are registers.
REQ-017 SHALL toggle the parity bit on every cpu_ce, independent of state.
REQ-018 IDLE: on cpu_ce with cpu_wr=1 and cpu_addr=DMA_REG_ADDR, SHALL latch page<=cpu_data_out, clear cnt to 0, and go to HALT.
REQ-019 HALT: on the next cpu_ce, SHALL go to ALIGN if parity=1, else to READ.
REQ-020 ALIGN: on the next cpu_ce, SHALL go to READ.
REQ-021 READ: SHALL drive dma_addr={page,cnt} and bus_sel=1; on cpu_ce, data<=wram_data_in and go to WRITE.
REQ-022 WRITE: SHALL drive oam_addr=cnt, oam_data_in=data and oam_we=cpu_ce; on cpu_ce, cnt<=cnt+1 (8-bit wrap).
REQ-023 WRITE: if cnt=8'hFF on that cpu_ce, SHALL go to IDLE, otherwise to READ.
REQ-024 cpu_rdy SHALL be 0 and oam_dma 1 in every state except IDLE.
REQ-025 Outputs SHALL be Moore-decoded from the registered state; oam_we is the only output gated by cpu_ce.
REQ-026 A full transfer SHALL hold cpu_rdy low for 513 cpu_ce cycles when entering HALT with parity=0, and 514 when parity=1.
REQ-027 SHALL move exactly 256 bytes, ascending from {page,8'h00} to {page,8'hFF}.
REQ-028 SHALL ignore writes to DMA_REG_ADDR while not in IDLE.
REQ-029 SHALL hold all state, including the READ to WRITE data, while cpu_ce=0.
REQ-030 Outside IDLE, SHALL ignore writes to any other address.
REQ-031 Outside READ, dma_addr SHALL be {page,cnt}.
REQ-032 bus_sel SHALL be 0 outside READ.
REQ-033 oam_we SHALL be 0 outside WRITE.

Reset
REQ-034 While reset=1, SHALL force state=IDLE, page=0, cnt=0, data=0 and parity=0.
REQ-035 During reset, outputs SHALL be: cpu_rdy=1, oam_dma=0, bus_sel=0, oam_we=0, dma_addr=0, oam_addr=0, oam_data_in=0.
REQ-036 Reset asserted mid-transfer SHALL abort immediately with no further oam_we pulse; the next trigger after release SHALL start a fresh 256-byte transfer.

Structure
REQ-037 The state enum dma_state_t and the constant DMA_REG_ADDR_DEFAULT SHALL live in shared package nes_pkg.
REQ-038 SHALL be a single module with no sub-module; the FSM plus counters fit in one block.

Verification
REQ-039 Even-parity trigger, page 8'h02, WRAM[16'h0200+i]=i^8'h5A: SHALL give cpu_rdy low for 513 ce cycles and OAM[i]=i^8'h5A for all 256 bytes.
REQ-040 Trigger with parity=1: SHALL give exactly one ALIGN cycle and cpu_rdy low for 514 ce cycles.
REQ-041 cpu_ce toggled 1-0-0-1 randomly during transfer: SHALL produce no missed or duplicate oam_we, identical OAM contents, and a last write at oam_addr=8'hFF.
REQ-042 Second write to 16'h4014 (data 8'h07) at byte 100: SHALL be ignored, with the transfer completing from page 8'h02.
REQ-043 reset pulse at byte 37: SHALL give cpu_rdy=1 and oam_we=0 at once; a retrigger with page 8'h03 SHALL restart at 16'h0300.
REQ-044 Write to 16'h4015 or a read of 16'h4014: SHALL leave the block in IDLE with cpu_rdy=1.
